// File: rtl/dmem_pkg.sv
// Shared types and widths for the main data memory and the
// cache controller's memory-side FSM.
package dmem_pkg;

    localparam int BLOCK_W    = 128;
    localparam int MEM_ADDR_W = 28;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } op_e;

endpackage

// File: rtl/dmem_if.sv
// Cache <-> main memory block handshake bundle.
// The cache side is the master; the memory side is the slave.
interface dmem_if;
    import dmem_pkg::*;

    logic                  MEM_READ;
    logic                  MEM_WRITE;
    logic [MEM_ADDR_W-1:0] MEM_ADDRESS;
    logic [BLOCK_W-1:0]    MEM_WRITEDATA;
    logic [BLOCK_W-1:0]    MEM_READDATA;
    logic                  MEM_BUSYWAIT;

    modport master (
        output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
        input  MEM_READDATA, MEM_BUSYWAIT
    );

    modport slave (
        input  MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
        output MEM_READDATA, MEM_BUSYWAIT
    );

endinterface

// File: rtl/data_memory_block_array.sv
// Block storage: registered read, single-port write,
// synchronous clear of every block on RESET.
module dmem_block_array
    import dmem_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               we_i,
    input  logic               re_i,
    input  logic [AW-1:0]      addr_i,
    input  logic [BLOCK_W-1:0] wdata_i,
    output logic [BLOCK_W-1:0] rdata_o
);

    logic [BLOCK_W-1:0] mem_q [2**AW];
    logic [BLOCK_W-1:0] rdata_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 2**AW; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end
            if (re_i) begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_block.sv
// Main data memory behind the L1 D-cache: block refills and
// write-backs with a fixed multi-cycle busywait latency.
module data_memory_block
    import dmem_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 5
) (
    input logic   CLK,
    input logic   RESET,
    dmem_if.slave mem
);

    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);
    localparam bit         LAT1     = (LATENCY == 1);

    state_e                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    op_e                   op_q, op_d;
    logic [MEM_ADDR_W-1:0] addr_q, addr_d;
    logic [BLOCK_W-1:0]    wdata_q, wdata_d;

    logic                  req, changed, start, done;
    op_e                   op_in, cur_op;
    logic [ADDR_BITS-1:0]  blk_addr;
    logic [BLOCK_W-1:0]    cur_wdata;

    assign req     = mem.MEM_READ | mem.MEM_WRITE;
    assign op_in   = mem.MEM_WRITE ? OP_WRITE : OP_READ;
    assign changed = (op_in != op_q) ||
                     (mem.MEM_ADDRESS != addr_q);

    // A DONE cycle with a different request starts a new access
    // immediately, so write-back -> refill has no idle gap.
    assign start = req && ((state_q == IDLE) ||
                           (state_q == DONE && changed));

    assign done = (start && LAT1) ||
                  (state_q == BUSY && cnt_q == 8'd1);

    assign cur_op    = start ? op_in : op_q;
    assign blk_addr  = start ? mem.MEM_ADDRESS[ADDR_BITS-1:0]
                             : addr_q[ADDR_BITS-1:0];
    assign cur_wdata = start ? mem.MEM_WRITEDATA : wdata_q;

    assign mem.MEM_BUSYWAIT = !RESET &&
                              (start || state_q == BUSY);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_READ;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    op_d    = op_in;
                    addr_d  = mem.MEM_ADDRESS;
                    wdata_d = mem.MEM_WRITEDATA;
                    cnt_d   = CNT_LOAD;
                    state_d = LAT1 ? DONE : BUSY;
                end else if (!req) begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    dmem_block_array #(
        .AW (ADDR_BITS)
    ) u_array (
        .CLK     (CLK),
        .RESET   (RESET),
        .we_i    (done && cur_op == OP_WRITE),
        .re_i    (done && cur_op == OP_READ),
        .addr_i  (blk_addr),
        .wdata_i (cur_wdata),
        .rdata_o (mem.MEM_READDATA)
    );

endmodule
